csr_file: RTL and testbench

- Machine-mode CSR register file for the RV32 core. It is the storage end of the CSR read-modify-write path.
- Read side: supplies the current CSR value (cdata) to the CSR ALU.
- Write side: commits the ALU result in the writeback stage.
- Also owns trap entry/return state (mstatus, mepc, mcause, mtval), interrupt pending/enable, and the 64-bit mcycle/minstret counters.

---
 rtl/csr_file_pkg.sv | 73 +++++++
 rtl/csr_file_counter.sv | 28 ++
 rtl/csr_file.sv | 181 ++++++++++++++++++
 tb/tb_csr_file.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/csr_file_pkg.sv
// csr_file_pkg: shared CSR address map, bit positions and bundle types
// for the machine-mode CSR register file and its CSR ALU neighbour.
package csr_file_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIP_MSIP     = 3;
    localparam int MIP_MTIP     = 7;
    localparam int MIP_MEIP     = 11;

    typedef struct packed {
        logic        crden;
        logic [11:0] craddr;
        logic        cwren;
        logic [11:0] cwaddr;
        logic [31:0] cwdata;
        logic        retire;
        logic        exception;
        logic        interrupt;
        logic [3:0]  ecause;
        logic [31:0] epc;
        logic [31:0] etval;
        logic        mret;
        logic        ext_irq;
        logic        tim_irq;
        logic        sw_irq;
    } csr_file_in_type;

    typedef struct packed {
        logic [31:0] crdata;
        logic        illegal;
        logic        irpt;
        logic [31:0] mtvec;
        logic [31:0] mepc;
    } csr_file_out_type;

    // Address decodes to something this file stores or synthesises.
    function automatic logic csr_implemented(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC,
            CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
            CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH,
            CSR_MINSTRETH, CSR_CYCLE, CSR_INSTRET, CSR_CYCLEH,
            CSR_INSTRETH, CSR_MHARTID: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Writes to these are flagged; misa writes are silently ignored instead.
    function automatic logic csr_readonly(input logic [11:0] addr);
        return (addr[11:10] == 2'b11) || (addr == CSR_MIP);
    endfunction

endpackage

// File: rtl/csr_file_counter.sv
// csr_counter: 64-bit wrapping counter with an increment enable and
// independently writable low/high halves; a write suppresses counting.
import csr_file_pkg::*;

module csr_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    // Half writes replace only their half; carry comes from the full
    // 64-bit add, so it only happens when neither half is written.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= 64'd0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) count[31:0]  <= wdata;
            if (wr_hi) count[63:32] <= wdata;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR storage with trap entry/return state,
// interrupt pending/enable and the mcycle/minstret counters.
import csr_file_pkg::*;

module csr_file #(
    parameter logic [31:0] HARTID = 32'd0,
    parameter logic [31:0] MISA   = 32'h40000100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        crden,
    input  logic [11:0] craddr,
    output logic [31:0] crdata,
    input  logic        cwren,
    input  logic [11:0] cwaddr,
    input  logic [31:0] cwdata,
    output logic        illegal,
    input  logic        retire,
    input  logic        exception,
    input  logic        interrupt,
    input  logic [3:0]  ecause,
    input  logic [31:0] epc,
    input  logic [31:0] etval,
    input  logic        mret,
    input  logic        ext_irq,
    input  logic        tim_irq,
    input  logic        sw_irq,
    output logic        irpt,
    output logic [31:0] mtvec,
    output logic [31:0] mepc
);

    csr_file_in_type  d;
    csr_file_out_type q;

    assign d.crden     = crden;
    assign d.craddr    = craddr;
    assign d.cwren     = cwren;
    assign d.cwaddr    = cwaddr;
    assign d.cwdata    = cwdata;
    assign d.retire    = retire;
    assign d.exception = exception;
    assign d.interrupt = interrupt;
    assign d.ecause    = ecause;
    assign d.epc       = epc;
    assign d.etval     = etval;
    assign d.mret      = mret;
    assign d.ext_irq   = ext_irq;
    assign d.tim_irq   = tim_irq;
    assign d.sw_irq    = sw_irq;

    assign crdata  = q.crdata;
    assign illegal = q.illegal;
    assign irpt    = q.irpt;
    assign mtvec   = q.mtvec;
    assign mepc    = q.mepc;

    logic        st_mie;
    logic        st_mpie;
    logic [2:0]  ie;
    logic [2:0]  ip;
    logic [31:0] tvec;
    logic [31:0] scratch;
    logic [31:0] epc_r;
    logic [31:0] cause;
    logic [31:0] tval;
    logic [63:0] cyc;
    logic [63:0] ins;
    logic        we;

    // Trap entry and return own the edge; any concurrent write is dropped.
    assign we = d.cwren && !d.exception && !d.mret
             && csr_implemented(d.cwaddr)
             && !csr_readonly(d.cwaddr);

    // Trap state and software-writable registers, exception > mret > write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
            ie      <= 3'd0;
            tvec    <= 32'd0;
            scratch <= 32'd0;
            epc_r   <= 32'd0;
            cause   <= 32'd0;
            tval    <= 32'd0;
        end else if (d.exception) begin
            epc_r   <= d.epc & ~32'd3;
            cause   <= {d.interrupt, 27'd0, d.ecause};
            tval    <= d.etval;
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
        end else if (d.mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (we) begin
            case (d.cwaddr)
                CSR_MSTATUS: begin
                    st_mie  <= d.cwdata[MSTATUS_MIE];
                    st_mpie <= d.cwdata[MSTATUS_MPIE];
                end
                CSR_MIE: ie <= {d.cwdata[MIP_MEIP],
                                d.cwdata[MIP_MTIP],
                                d.cwdata[MIP_MSIP]};
                CSR_MTVEC:    tvec    <= d.cwdata & ~32'd3;
                CSR_MSCRATCH: scratch <= d.cwdata;
                CSR_MEPC:     epc_r   <= d.cwdata & ~32'd3;
                CSR_MCAUSE:   cause   <= d.cwdata;
                CSR_MTVAL:    tval    <= d.cwdata;
                default: ;
            endcase
        end
    end

    // Interrupt lines sampled once per cycle into mip {MEIP,MTIP,MSIP}.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ip <= 3'd0;
        else       ip <= {d.ext_irq, d.tim_irq, d.sw_irq};
    end

    csr_counter u_mcycle (
        .clock (clock),
        .reset (reset),
        .inc   (1'b1),
        .wr_lo (we && (d.cwaddr == CSR_MCYCLE)),
        .wr_hi (we && (d.cwaddr == CSR_MCYCLEH)),
        .wdata (d.cwdata),
        .count (cyc)
    );

    csr_counter u_minstret (
        .clock (clock),
        .reset (reset),
        .inc   (d.retire),
        .wr_lo (we && (d.cwaddr == CSR_MINSTRET)),
        .wr_hi (we && (d.cwaddr == CSR_MINSTRETH)),
        .wdata (d.cwdata),
        .count (ins)
    );

    // Zero-latency read mux, status/flags and direct register outputs.
    always_comb begin
        q.crdata  = 32'd0;
        q.illegal = (d.crden && !csr_implemented(d.craddr))
                 || (d.cwren && (!csr_implemented(d.cwaddr)
                                 || csr_readonly(d.cwaddr)));
        q.irpt    = st_mie && |(ie & ip);
        q.mtvec   = tvec;
        q.mepc    = epc_r;
        case (d.craddr)
            CSR_MSTATUS: begin
                q.crdata[12:11]        = 2'b11;
                q.crdata[MSTATUS_MPIE] = st_mpie;
                q.crdata[MSTATUS_MIE]  = st_mie;
            end
            CSR_MISA: q.crdata = MISA;
            CSR_MIE: begin
                q.crdata[MIP_MEIP] = ie[2];
                q.crdata[MIP_MTIP] = ie[1];
                q.crdata[MIP_MSIP] = ie[0];
            end
            CSR_MTVEC:    q.crdata = tvec;
            CSR_MSCRATCH: q.crdata = scratch;
            CSR_MEPC:     q.crdata = epc_r;
            CSR_MCAUSE:   q.crdata = cause;
            CSR_MTVAL:    q.crdata = tval;
            CSR_MIP: begin
                q.crdata[MIP_MEIP] = ip[2];
                q.crdata[MIP_MTIP] = ip[1];
                q.crdata[MIP_MSIP] = ip[0];
            end
            CSR_MCYCLE,   CSR_CYCLE:    q.crdata = cyc[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:   q.crdata = cyc[63:32];
            CSR_MINSTRET, CSR_INSTRET:  q.crdata = ins[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: q.crdata = ins[63:32];
            CSR_MHARTID:  q.crdata = HARTID;
            default:      q.crdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed self-checking bench for csr_file with
// hand-computed expectations checked by immediate assertions.
module tb_csr_file;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        crden = 1'b0;
    logic [11:0] craddr = 12'h0;
    logic [31:0] crdata;
    logic        cwren = 1'b0;
    logic [11:0] cwaddr = 12'h0;
    logic [31:0] cwdata = 32'h0;
    logic        illegal;
    logic        retire = 1'b0;
    logic        exception = 1'b0;
    logic        interrupt = 1'b0;
    logic [3:0]  ecause = 4'h0;
    logic [31:0] epc = 32'h0;
    logic [31:0] etval = 32'h0;
    logic        mret = 1'b0;
    logic        ext_irq = 1'b0;
    logic        tim_irq = 1'b0;
    logic        sw_irq = 1'b0;
    logic        irpt;
    logic [31:0] mtvec;
    logic [31:0] mepc;

    int passed = 0;
    int total  = 0;

    csr_file dut (
        .clock     (clock),
        .reset     (reset),
        .crden     (crden),
        .craddr    (craddr),
        .crdata    (crdata),
        .cwren     (cwren),
        .cwaddr    (cwaddr),
        .cwdata    (cwdata),
        .illegal   (illegal),
        .retire    (retire),
        .exception (exception),
        .interrupt (interrupt),
        .ecause    (ecause),
        .epc       (epc),
        .etval     (etval),
        .mret      (mret),
        .ext_irq   (ext_irq),
        .tim_irq   (tim_irq),
        .sw_irq    (sw_irq),
        .irpt      (irpt),
        .mtvec     (mtvec),
        .mepc      (mepc)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input string tag,
                      input logic [11:0] a,
                      input logic [31:0] exp);
        crden  = 1'b1;
        craddr = a;
        #1;
        chk(tag, crdata, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] v);
        cwren  = 1'b1;
        cwaddr = a;
        cwdata = v;
        tick();
        cwren  = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (50) tick();
        rd("mcycle_50", 12'hB00, 32'd50);

        reset = 1'b1;
        #1;
        chk("mcycle_rst", crdata, 32'd0);
        rd("mstatus_rst", 12'h300, 32'h00001800);
        chk("irpt_rst", {31'd0, irpt}, 32'd0);
        chk("mtvec_rst", mtvec, 32'd0);
        chk("mepc_rst", mepc, 32'd0);
        reset = 1'b0;
        tick();

        rd("misa", 12'h301, 32'h40000100);
        rd("mhartid", 12'hF14, 32'd0);
        craddr = 12'h7C0;
        #1;
        chk("rd_unimpl_illegal", {31'd0, illegal}, 32'd1);
        chk("rd_unimpl_data", crdata, 32'd0);

        wr(12'h305, 32'h00000103);
        rd("mtvec_rd", 12'h305, 32'h00000100);
        chk("mtvec_out", mtvec, 32'h00000100);
        chk("legal_rd", {31'd0, illegal}, 32'd0);

        wr(12'h300, 32'hFFFF_FF08);
        rd("mstatus_mie", 12'h300, 32'h00001808);
        wr(12'h304, 32'h00000080);
        rd("mie_rd", 12'h304, 32'h00000080);
        chk("irpt_no_irq", {31'd0, irpt}, 32'd0);
        tim_irq = 1'b1;
        #1;
        chk("irpt_same_cycle", {31'd0, irpt}, 32'd0);
        tick();
        chk("irpt_set", {31'd0, irpt}, 32'd1);
        rd("mip_rd", 12'h344, 32'h00000080);
        wr(12'h304, 32'h00000000);
        chk("irpt_mie0", {31'd0, irpt}, 32'd0);

        wr(12'h340, 32'hA5A5A5A5);
        exception = 1'b1;
        interrupt = 1'b1;
        ecause    = 4'd7;
        epc       = 32'h00001006;
        etval     = 32'h00000055;
        cwren     = 1'b1;
        cwaddr    = 12'h340;
        cwdata    = 32'h12345678;
        tick();
        exception = 1'b0;
        interrupt = 1'b0;
        cwren     = 1'b0;
        rd("mcause", 12'h342, 32'h80000007);
        chk("mepc_trap", mepc, 32'h00001004);
        rd("mtval", 12'h343, 32'h00000055);
        rd("mstatus_trap", 12'h300, 32'h00001880);
        rd("mscratch_kept", 12'h340, 32'hA5A5A5A5);

        mret   = 1'b1;
        cwren  = 1'b1;
        cwaddr = 12'h340;
        cwdata = 32'h0BADF00D;
        tick();
        mret  = 1'b0;
        cwren = 1'b0;
        rd("mstatus_mret", 12'h300, 32'h00001888);
        chk("mepc_mret", mepc, 32'h00001004);
        rd("mscratch_mret", 12'h340, 32'hA5A5A5A5);

        wr(12'hB00, 32'hFFFFFFFF);
        rd("mcycle_wr", 12'hB00, 32'hFFFFFFFF);
        rd("mcycleh_pre", 12'hB80, 32'd0);
        tick();
        rd("mcycle_wrap", 12'hB00, 32'd0);
        rd("mcycleh_carry", 12'hB80, 32'd1);
        cwren  = 1'b1;
        cwaddr = 12'hC00;
        cwdata = 32'h00001234;
        #1;
        chk("wr_ro_illegal", {31'd0, illegal}, 32'd1);
        tick();
        cwren = 1'b0;
        rd("mcycle_ro_wr", 12'hB00, 32'd1);
        rd("cycle_shadow", 12'hC00, 32'd1);

        exception = 1'b1;
        cwren     = 1'b1;
        cwaddr    = 12'hB00;
        cwdata    = 32'h00000100;
        tick();
        exception = 1'b0;
        cwren     = 1'b0;
        rd("mcycle_exc_drop", 12'hB00, 32'd2);

        rd("minstret_0", 12'hB02, 32'd0);
        retire = 1'b1;
        repeat (3) tick();
        retire = 1'b0;
        rd("minstret_3", 12'hB02, 32'd3);
        rd("instret_shadow", 12'hC02, 32'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
